motor_rate_ramp: RTL and testbench

- Rate controller for the motor step clock: owns a runtime-programmable toggle divider and sequences its divide factor.
- Speed changes are ramps, not jumps. Target half-periods are accepted through a valid/ready handshake. On each ramp tick the live factor steps toward the target, and a stop request ramps down to the slowest rate before the clock is parked low.
- Sits between the remote-command decoder and the motor driver; replaces fixed-factor dividers on the step path.

---
 rtl/motor_rate_pkg.sv | 13 +
 rtl/motor_ramp_tick.sv | 37 +++
 rtl/motor_rate_ramp.sv | 127 ++++++++++++
 tb/tb_motor_rate_ramp.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_rate_pkg.sv
// Shared definitions for the motor step-clock rate controller.
package motor_rate_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2,
        S_STOP = 2'd3
    } rate_state_t;

    localparam int unsigned FACTOR_STOP = 0;

endpackage

// File: rtl/motor_ramp_tick.sv
// Ramp prescaler: one-cycle tick every RAMP_DIV enabled cycles, synchronous clear.
module motor_ramp_tick #(
    parameter int unsigned RAMP_DIV = 240000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(RAMP_DIV - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (pcnt == LAST) begin
                pcnt <= '0;
                tick <= 1'b1;
            end else begin
                pcnt <= pcnt + PW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/motor_rate_ramp.sv
// Motor step-clock rate controller: toggle divider whose half-period ramps toward a target.
// Optional macro MOTOR_RATE_STEP_CNT_EN adds the step_cnt rising-edge counter output.
module motor_rate_ramp
    import motor_rate_pkg::*;
#(
    parameter int unsigned DIV_W        = 24,
    parameter int unsigned FACTOR_START = 24000,
    parameter int unsigned FACTOR_MIN   = 240,
    parameter int unsigned RAMP_DIV     = 240000,
    parameter int unsigned RAMP_STEP    = 200
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_factor,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic [DIV_W-1:0] cur_factor,
    output logic             busy,
    output logic             at_speed
`ifdef MOTOR_RATE_STEP_CNT_EN
    ,
    output logic [15:0]      step_cnt
`endif
);

    localparam logic [DIV_W-1:0] F_START = DIV_W'(FACTOR_START);
    localparam logic [DIV_W-1:0] F_MIN   = DIV_W'(FACTOR_MIN);
    localparam logic [DIV_W-1:0] F_STEP  = DIV_W'(RAMP_STEP);
    localparam logic [DIV_W-1:0] F_STOP  = DIV_W'(FACTOR_STOP);

    rate_state_t      state, nxt_state;
    logic [DIV_W-1:0] cnt, target, nxt_target, nxt_factor, step_val, clamped;
    logic             accept, is_stop, wrap, ramping, apply, pending, tick, tick_clr;

    always_comb begin
        accept   = cfg_valid && cfg_ready;
        is_stop  = (cfg_factor == F_STOP);
        clamped  = is_stop ? '0 :
                   (cfg_factor < F_MIN)   ? F_MIN :
                   (cfg_factor > F_START) ? F_START : cfg_factor;
        ramping  = (state == S_RAMP) || (state == S_STOP);
        wrap     = (state != S_IDLE) && (cnt == cur_factor - DIV_W'(1));
        // Ticks are only latched as a pending step; the factor moves at a wrap.
        apply    = wrap && ramping && (pending || tick);
        if (cur_factor < target)
            step_val = (target - cur_factor > F_STEP) ? cur_factor + F_STEP : target;
        else
            step_val = (cur_factor - target > F_STEP) ? cur_factor - F_STEP : target;
        nxt_factor = apply ? step_val : cur_factor;

        nxt_state  = state;
        nxt_target = target;
        case (state)
            S_IDLE: if (accept && !is_stop) begin
                nxt_state  = S_RAMP;
                nxt_target = clamped;
            end
            S_RAMP: if (wrap && nxt_factor == target) nxt_state = S_HOLD;
            S_HOLD: if (accept) begin
                if (is_stop) begin
                    nxt_state  = S_STOP;
                    nxt_target = F_START;
                end else if (clamped != target) begin
                    nxt_state  = S_RAMP;
                    nxt_target = clamped;
                end
            end
            S_STOP: if (wrap && clk_out && cur_factor == F_START) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        tick_clr = ((nxt_state == S_RAMP) || (nxt_state == S_STOP)) && !ramping;
    end

    motor_ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (ramping),
        .clr    (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            clk_out    <= 1'b0;
            cur_factor <= F_START;
            target     <= F_START;
            pending    <= 1'b0;
            cfg_ready  <= 1'b1;
            busy       <= 1'b0;
            at_speed   <= 1'b0;
        end else begin
            state      <= nxt_state;
            target     <= nxt_target;
            cur_factor <= nxt_factor;
            if (state == S_IDLE || nxt_state == S_IDLE || wrap)
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
            if (nxt_state == S_IDLE)
                clk_out <= 1'b0;
            else if (wrap)
                clk_out <= ~clk_out;
            if (!ramping || tick_clr || wrap)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;
            cfg_ready <= (nxt_state == S_IDLE) || (nxt_state == S_HOLD);
            busy      <= (nxt_state == S_RAMP) || (nxt_state == S_STOP);
            at_speed  <= (nxt_state == S_HOLD);
        end
    end

`ifdef MOTOR_RATE_STEP_CNT_EN
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            step_cnt <= '0;
        else if (accept)
            step_cnt <= '0;
        else if (wrap && !clk_out)
            step_cnt <= step_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_motor_rate_ramp.sv
// Self-checking bench for motor_rate_ramp using a toggle-time reference model.
module tb_motor_rate_ramp;

    localparam int FS = 20;
    localparam int FMIN = 2;
    localparam int RD = 10;
    localparam int RS = 4;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_factor = 8'd0;
    logic       cfg_ready, clk_out, busy, at_speed;
    logic [7:0] cur_factor;
`ifdef MOTOR_RATE_STEP_CNT_EN
    logic [15:0] step_cnt;
`endif

    motor_rate_ramp #(
        .DIV_W(8), .FACTOR_START(FS), .FACTOR_MIN(FMIN), .RAMP_DIV(RD), .RAMP_STEP(RS)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_factor (cfg_factor),
        .cfg_ready  (cfg_ready),
        .clk_out    (clk_out),
        .cur_factor (cur_factor),
        .busy       (busy),
        .at_speed   (at_speed)
`ifdef MOTOR_RATE_STEP_CNT_EN
        ,
        .step_cnt   (step_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_tog = 0;
    int   rises = 0;
    logic prev_clk = 1'b0;

    // Edge index and toggle history, sampled shortly after each rising edge.
    always @(posedge clk_in) begin
        #2;
        cyc++;
        if (clk_out !== prev_clk) begin
            last_tog = cyc;
            if (clk_out === 1'b1) rises++;
        end
        prev_clk = clk_out;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int clampf(input int x);
        if (x == 0) return 0;
        if (x < FMIN) return FMIN;
        if (x > FS) return FS;
        return x;
    endfunction

    function automatic int stepf(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur <= RS) ? tgt : cur + RS;
        return (cur - tgt <= RS) ? tgt : cur - RS;
    endfunction

    // Number of ramp ticks that have taken effect by edge x, counted from the accept edge.
    function automatic int ticks(input int x, input int acc);
        return (x - acc >= 1) ? (x - acc - 1) / RD : 0;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        cfg_valid = 1'b0;
        cfg_factor = 8'd0;
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic accept(input int v, input bit keep, output int acc);
        int n = 0;
        cfg_factor = 8'(v);
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cfg_ready=%b after %0d cycles, required 1", cfg_ready, n);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        acc = cyc;
        if (!keep) cfg_valid = 1'b0;
    endtask

    // Walks the expected toggle schedule: each half-period lasts the factor in force,
    // and a factor step lands on a toggle if a ramp tick fell since the previous toggle.
    task automatic follow(input int tgt, input int acc, input int first_tog, input int cur0,
                          input bit stop_mode, input bit steady);
        int cur = cur0;
        int e = first_tog;
        int prev_e = acc;
        int t;
        bit lvl = clk_out;
        for (int it = 0; it < 60; it++) begin
            while (clk_out === lvl && cyc < e + FS + 5) @(negedge clk_in);
            t = cyc;
            checks++;
            if (t != e) begin
                failures++;
                $display("FAIL toggle_time: toggle at edge %0d, required edge %0d", t - acc, e - acc);
                return;
            end
            if (stop_mode && cur == FS && lvl) begin
                checks++;
                if (clk_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
                    at_speed !== 1'b0 || cur_factor !== 8'(FS)) begin
                    failures++;
                    $display("FAIL park: clk=%b busy=%b rdy=%b at=%b cur=%0d, required 0 0 1 0 %0d",
                             clk_out, busy, cfg_ready, at_speed, cur_factor, FS);
                end
                return;
            end
            if (ticks(e, acc) > ticks(prev_e, acc)) cur = stepf(cur, tgt);
            checks++;
            if (cur_factor !== 8'(cur)) begin
                failures++;
                $display("FAIL cur_factor: got %0d at edge %0d, required %0d", cur_factor, e - acc, cur);
            end
            lvl = ~lvl;
            prev_e = e;
            if (!stop_mode && cur == tgt) begin
                checks++;
                if (at_speed !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_flags: at=%b busy=%b rdy=%b, required 1 0 1", at_speed, busy, cfg_ready);
                end
                if (steady) begin
                    while (clk_out === lvl && cyc < e + FS + 5) @(negedge clk_in);
                    checks++;
                    if (cyc != e + cur) begin
                        failures++;
                        $display("FAIL steady_half: got %0d cycles, required %0d", cyc - e, cur);
                    end
                end
                return;
            end
            checks++;
            if (busy !== 1'b1 || cfg_ready !== 1'b0 || at_speed !== 1'b0) begin
                failures++;
                $display("FAIL ramp_flags: busy=%b rdy=%b at=%b, required 1 0 0", busy, cfg_ready, at_speed);
            end
            e = e + cur;
        end
        checks++;
        failures++;
        $display("FAIL follow_len: ramp to %0d did not settle, required settle", tgt);
    endtask

    task automatic test_reset();
        int acc;
        do_reset();
        checks++;
        if (clk_out !== 1'b0 || cur_factor !== 8'(FS) || cfg_ready !== 1'b1 ||
            busy !== 1'b0 || at_speed !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: clk=%b cur=%0d rdy=%b busy=%b at=%b, required 0 %0d 1 0 0",
                     clk_out, cur_factor, cfg_ready, busy, at_speed, FS);
        end
        accept(0, 0, acc);
        repeat (30) @(negedge clk_in);
        checks++;
        if (clk_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || last_tog > acc) begin
            failures++;
            $display("FAIL idle_zero: clk=%b busy=%b rdy=%b, required 0 0 1 and no toggles", clk_out, busy, cfg_ready);
        end
    endtask

    task automatic test_ramp_up();
        int acc;
        do_reset();
        accept(12, 0, acc);
        follow(12, acc, acc + FS, FS, 0, 1);
    endtask

    task automatic test_clamp();
        int acc;
        do_reset();
        accept(1, 0, acc);
        follow(2, acc, acc + FS, FS, 0, 1);
        do_reset();
        accept(200, 0, acc);
        follow(FS, acc, acc + FS, FS, 0, 1);
    endtask

    task automatic test_stop();
        int acc;
        do_reset();
        accept(12, 0, acc);
        follow(12, acc, acc + FS, FS, 0, 1);
        repeat ($urandom_range(0, 15)) @(negedge clk_in);
        accept(0, 0, acc);
        follow(FS, acc, last_tog + 12, 12, 1, 0);
        acc = cyc;
        repeat (30) @(negedge clk_in);
        checks++;
        if (clk_out !== 1'b0 || last_tog > acc || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL parked_idle: clk=%b rdy=%b, required 0 1 with no toggles", clk_out, cfg_ready);
        end
    endtask

    task automatic test_held_valid();
        int acc, h;
        do_reset();
        accept(12, 1, acc);
        cfg_factor = 8'd8;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_ramp: cfg_ready=%b, required 0", cfg_ready);
        end
        follow(12, acc, acc + FS, FS, 0, 0);
        h = cyc;
        @(negedge clk_in);
        checks++;
        if (cyc != h + 1 || busy !== 1'b1 || cfg_ready !== 1'b0 || at_speed !== 1'b0) begin
            failures++;
            $display("FAIL held_accept: busy=%b rdy=%b at=%b, required 1 0 0", busy, cfg_ready, at_speed);
        end
        cfg_valid = 1'b0;
        follow(8, h + 1, last_tog + 12, 12, 0, 1);
    endtask

    task automatic test_reset_mid();
        int acc, n, hi;
        do_reset();
        accept(12, 0, acc);
        n = 0;
        while (cur_factor !== 8'd16 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (clk_out !== 1'b1 || cur_factor !== 8'd16) begin
            failures++;
            $display("FAIL pre_abort: clk=%b cur=%0d, required 1 16", clk_out, cur_factor);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (clk_out !== 1'b0 || cur_factor !== 8'(FS) || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_abort: clk=%b cur=%0d busy=%b rdy=%b, required 0 %0d 0 1",
                     clk_out, cur_factor, busy, cfg_ready, FS);
        end
        @(negedge clk_in);
        rst = 1'b1;
        hi = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (clk_out !== 1'b0 || busy !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0 || at_speed !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_abort: %0d active cycles at=%b, required 0 0", hi, at_speed);
        end
    endtask

`ifdef MOTOR_RATE_STEP_CNT_EN
    task automatic test_step_cnt();
        int acc, base, n;
        do_reset();
        checks++;
        if (step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL step_cnt_reset: got %0d, required 0", step_cnt);
        end
        accept(12, 0, acc);
        base = rises;
        n = 0;
        while (rises - base < 5 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (step_cnt !== 16'(rises - base) || rises - base != 5) begin
            failures++;
            $display("FAIL step_cnt: got %0d, required 5", step_cnt);
        end
        accept(8, 0, acc);
        checks++;
        if (step_cnt !== 16'd0) begin
            failures++;
            $display("FAIL step_cnt_clear: got %0d, required 0", step_cnt);
        end
    endtask
`endif

    task automatic test_random();
        int acc, v, t, c;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            v = $urandom_range(1, 40);
            t = clampf(v);
            accept(v, 0, acc);
            follow(t, acc, acc + FS, FS, 0, 1);
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(0, 12)) @(negedge clk_in);
                v = $urandom_range(0, 40);
                c = clampf(v);
                accept(v, 0, acc);
                if (v == 0) begin
                    follow(FS, acc, last_tog + t, t, 1, 0);
                    break;
                end else if (c == t) begin
                    checks++;
                    if (at_speed !== 1'b1 || busy !== 1'b0 || cur_factor !== 8'(t)) begin
                        failures++;
                        $display("FAIL same_target: at=%b busy=%b cur=%0d, required 1 0 %0d",
                                 at_speed, busy, cur_factor, t);
                    end
                end else begin
                    follow(c, acc, last_tog + t, t, 0, 1);
                    t = c;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_stop();
        test_held_valid();
        test_reset_mid();
`ifdef MOTOR_RATE_STEP_CNT_EN
        test_step_cnt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
